// File: rtl/elevator_pkg.sv
// ---------------------------------------------------------------------------
// elevator_pkg
// Shared types and constants for the elevator hall-call front end.
//   NUM_FLOORS_C  : number of served floors
//   FLOOR_W       : width of the controller floor code
//   floor_code_t  : controller floor code, bit0 = between floors,
//                   bits [3:1] = floor index
//   req_vec_t     : one request bit per served floor
//   dwell_state_t : dwell FSM states
//   floor_index() : extracts the floor index from a floor code
// ---------------------------------------------------------------------------
package elevator_pkg;

  localparam int NUM_FLOORS_C = 6;
  localparam int FLOOR_W      = 4;

  typedef logic [FLOOR_W-1:0]      floor_code_t;
  typedef logic [NUM_FLOORS_C-1:0] req_vec_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DWELL = 1'b1
  } dwell_state_t;

  // Whole-floor index of a floor code; bit0 (between floors) is ignored here.
  function automatic logic [2:0] floor_index(input floor_code_t code);
    return code[3:1];
  endfunction

endpackage

// File: rtl/button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
// Conditions one raw hall-call button: 2-flop synchronizer, debounce counter
// with a stable output bit, and a one-clock pulse on each debounced press.
// Ports:
//   i_clk    : system clock
//   i_rst_n  : asynchronous active-low reset
//   i_raw    : asynchronous button input, active-high
//   o_press  : one-clock pulse when the stable value rises
// Parameter:
//   DEBOUNCE_CYCLES : consecutive differing samples needed to flip (>=1)
// ---------------------------------------------------------------------------
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // The counter only ever holds values below DEBOUNCE_CYCLES: the edge that
  // would reach it flips the stable bit instead. The press pulse is
  // registered on that same edge so it lasts exactly one clock.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_press  <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
        r_press  <= r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/floor_request_latch.sv
// ---------------------------------------------------------------------------
// floor_request_latch
// Turns raw hall-call buttons into the registered pending-request vector for
// the elevator controller. A request is latched on a debounced press and is
// cleared once the car has dwelt at that whole floor for DWELL_TICKS en ticks.
// Ports:
//   i_clk              : system clock
//   i_rst_n            : asynchronous active-low reset
//   i_en               : timebase tick shared with the controller
//   i_buttons_raw      : asynchronous hall-call buttons, active-high
//   i_lock_mask        : per-floor lock (only with FLOOR_LOCK_EN)
//   i_floor            : controller floor code (bit0 = between floors)
//   o_floors_triggered : registered pending-request vector
//   o_dwell_active     : high while a dwell is in progress
//   o_pending_count    : registered popcount of o_floors_triggered
// Build option:
//   FLOOR_LOCK_EN : adds i_lock_mask; locked floors ignore presses, drop any
//                   pending request and abort a dwell in progress.
// ---------------------------------------------------------------------------
module floor_request_latch
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS      = NUM_FLOORS_C,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DWELL_TICKS     = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic [NUM_FLOORS-1:0] i_buttons_raw,
`ifdef FLOOR_LOCK_EN
  input  logic [NUM_FLOORS-1:0] i_lock_mask,
`endif
  input  logic [FLOOR_W-1:0]    i_floor,
  output logic [NUM_FLOORS-1:0] o_floors_triggered,
  output logic                  o_dwell_active,
  output logic [2:0]            o_pending_count
);

  localparam int DCNT_W = $clog2(DWELL_TICKS + 1);
  localparam logic [DCNT_W:0] DWELL_DONE = (DCNT_W + 1)'(DWELL_TICKS);

  logic [NUM_FLOORS-1:0] w_press;
  logic [NUM_FLOORS-1:0] w_lock;
  logic [NUM_FLOORS-1:0] w_set;
  logic [NUM_FLOORS-1:0] w_clr;
  logic [2:0]            w_idx;
  logic [2:0]            w_pop;
  logic                  w_start;
  logic                  w_start_ok;
  logic                  w_abort;
  logic                  w_finish;
  logic                  w_press_dwell;
  logic                  w_lock_dwell;
  logic                  w_dwell_done;
  logic [DCNT_W:0]       w_cnt_next;

  dwell_state_t          r_state;
  logic [2:0]            r_dwell_floor;
  logic [DCNT_W-1:0]     r_dwell_cnt;
  logic [NUM_FLOORS-1:0] r_req;
  logic [2:0]            r_count;

  for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_raw  (i_buttons_raw[g]),
      .o_press(w_press[g])
    );
  end

`ifdef FLOOR_LOCK_EN
  assign w_lock = i_lock_mask;
`else
  assign w_lock = '0;
`endif

  // dwell_cnt counts en ticks already spent at the floor, so the tick whose
  // incremented count reaches DWELL_TICKS is the one that completes the
  // dwell. With DWELL_TICKS=1 that is the tick right after the start.
  always_comb begin
    w_idx         = floor_index(i_floor);
    w_start_ok    = 1'b0;
    w_press_dwell = 1'b0;
    w_lock_dwell  = 1'b0;
    w_pop         = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (w_idx == 3'(i)) begin
        w_start_ok = r_req[i] & ~w_lock[i];
      end
      if (r_dwell_floor == 3'(i)) begin
        w_press_dwell = w_press[i];
        w_lock_dwell  = w_lock[i];
      end
      w_pop = w_pop + {2'b00, r_req[i]};
    end
    w_cnt_next   = {1'b0, r_dwell_cnt} + (DCNT_W + 1)'(1);
    w_dwell_done = (w_cnt_next >= DWELL_DONE);
    w_start      = i_en & ~i_floor[0] & (w_idx < 3'(NUM_FLOORS)) & w_start_ok;
    w_abort      = (i_floor != {r_dwell_floor, 1'b0}) | w_lock_dwell;
    w_finish     = (r_state == DWELL) & ~w_abort & i_en & w_dwell_done;
  end

  // Clearing is ANDed out before the OR of new presses, so a press landing on
  // the clearing edge keeps the request alive for a fresh dwell.
  always_comb begin
    w_set = w_press & ~w_lock;
    w_clr = w_lock;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (w_finish && (r_dwell_floor == 3'(i))) begin
        w_clr[i] = 1'b1;
      end
    end
  end

  // The floor-change abort is checked on every clock; everything else in
  // the dwell only advances on en ticks, apart from a fresh press for the
  // dwell floor, which restarts the count immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_dwell_floor <= '0;
      r_dwell_cnt   <= '0;
    end else if (r_state == IDLE) begin
      if (w_start) begin
        r_state       <= DWELL;
        r_dwell_floor <= w_idx;
        r_dwell_cnt   <= DCNT_W'(1);
      end
    end else begin
      if (w_abort) begin
        r_state <= IDLE;
      end else if (i_en) begin
        if (w_dwell_done) begin
          r_state <= IDLE;
        end else if (w_press_dwell) begin
          r_dwell_cnt <= DCNT_W'(1);
        end else begin
          r_dwell_cnt <= w_cnt_next[DCNT_W-1:0];
        end
      end else if (w_press_dwell) begin
        r_dwell_cnt <= DCNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req   <= '0;
      r_count <= '0;
    end else begin
      r_req   <= (r_req & ~w_clr) | w_set;
      r_count <= w_pop;
    end
  end

  assign o_floors_triggered = r_req;
  assign o_dwell_active     = (r_state == DWELL);
  assign o_pending_count    = r_count;

endmodule

// File: tb/tb_floor_request_latch.sv
// ---------------------------------------------------------------------------
// tb_floor_request_latch
// Directed scenarios followed by randomized traffic for floor_request_latch,
// compared every cycle against a behavioural model of the request rules.
// ---------------------------------------------------------------------------
module tb_floor_request_latch;

  localparam int NumFloors      = 6;
  localparam int DebounceCycles = 4;
  localparam int DwellTicks     = 5;

  logic                 clk = 1'b0;
  logic                 rstN;
  logic                 en;
  logic [NumFloors-1:0] buttonsRaw;
  logic [3:0]           floorCode;
  logic [NumFloors-1:0] floorsTriggered;
  logic                 dwellActive;
  logic [2:0]           pendingCount;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state
  logic [NumFloors-1:0] rawQ[$];
  logic [NumFloors-1:0] sampleQ[$];
  logic [NumFloors-1:0] mStable;
  logic [NumFloors-1:0] mPress;
  logic [NumFloors-1:0] mReq;
  logic [2:0]           mCount;
  int                   mDwellFloor;
  int                   mServed;

  floor_request_latch #(
    .NUM_FLOORS     (NumFloors),
    .DEBOUNCE_CYCLES(DebounceCycles),
    .DWELL_TICKS    (DwellTicks)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rstN),
    .i_en              (en),
    .i_buttons_raw     (buttonsRaw),
    .i_floor           (floorCode),
    .o_floors_triggered(floorsTriggered),
    .o_dwell_active    (dwellActive),
    .o_pending_count   (pendingCount)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [7:0] observed,
                            input logic [7:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    rawQ.delete();
    sampleQ.delete();
    mStable     = '0;
    mPress      = '0;
    mReq        = '0;
    mCount      = '0;
    mDwellFloor = -1;
    mServed     = 0;
  endtask

  // One clock edge of the request rules: the button value the debouncer
  // judges is the raw value from two edges earlier; a button flips once its
  // last DebounceCycles samples all disagree with its stable value; a press
  // sets the request one edge later; a dwell clears it after DwellTicks ticks.
  task automatic modelEdge();
    logic [NumFloors-1:0] sample;
    logic [NumFloors-1:0] pressNow;
    logic [NumFloors-1:0] clrMask;
    bit                   allDiffer;
    rawQ.push_back(buttonsRaw);
    if (rawQ.size() > 3) void'(rawQ.pop_front());
    sample = (rawQ.size() == 3) ? rawQ[0] : '0;
    sampleQ.push_back(sample);
    if (sampleQ.size() > DebounceCycles) void'(sampleQ.pop_front());
    pressNow = '0;
    for (int i = 0; i < NumFloors; i++) begin
      if (sampleQ.size() == DebounceCycles) begin
        allDiffer = 1'b1;
        for (int k = 0; k < DebounceCycles; k++)
          if (sampleQ[k][i] == mStable[i]) allDiffer = 1'b0;
        if (allDiffer) begin
          mStable[i]  = ~mStable[i];
          pressNow[i] = mStable[i];
        end
      end
    end
    clrMask = '0;
    if (mDwellFloor < 0) begin
      if (en && !floorCode[0] && floorCode[3:1] < NumFloors && mReq[floorCode[3:1]]) begin
        mDwellFloor = int'(floorCode[3:1]);
        mServed     = 1;
      end
    end else if (int'(floorCode) != 2 * mDwellFloor) begin
      mDwellFloor = -1;
    end else if (en) begin
      if (mServed + 1 >= DwellTicks) begin
        clrMask[mDwellFloor] = 1'b1;
        mDwellFloor = -1;
      end else begin
        mServed = mPress[mDwellFloor] ? 1 : mServed + 1;
      end
    end else if (mPress[mDwellFloor]) begin
      mServed = 1;
    end
    mCount = 3'($countones(mReq));
    mReq   = (mReq & ~clrMask) | mPress;
    mPress = pressNow;
  endtask

  task automatic checkOutput();
    checkValue("floors_triggered", {2'b00, floorsTriggered}, {2'b00, mReq});
    checkValue("dwell_active", {7'd0, dwellActive}, {7'd0, (mDwellFloor >= 0)});
    checkValue("pending_count", {5'd0, pendingCount}, {5'd0, mCount});
  endtask

  // Drive inputs at the falling edge, clock once, then compare at the next
  // falling edge.
  task automatic applyStimulus(input logic enV, input logic [NumFloors-1:0] btn,
                               input logic [3:0] flr);
    en         = enV;
    buttonsRaw = btn;
    floorCode  = flr;
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic enTick(input logic [NumFloors-1:0] btn, input logic [3:0] flr,
                        input int gap);
    repeat (gap - 1) applyStimulus(1'b0, btn, flr);
    applyStimulus(1'b1, btn, flr);
  endtask

  // Reset asserted between clock edges; outputs must drop without a clock.
  task automatic asyncReset();
    #2 rstN = 1'b0;
    #1;
    checkValue("async_rst_ft", {2'b00, floorsTriggered}, 8'h00);
    checkValue("async_rst_dwell", {7'd0, dwellActive}, 8'h00);
    checkValue("async_rst_count", {5'd0, pendingCount}, 8'h00);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    checkOutput();
    rstN = 1'b1;
  endtask

  // Directed scenarios, then randomized traffic, then the summary
  initial begin
    logic [NumFloors-1:0] btnState;
    logic [3:0]           flrState;
    rstN       = 1'b0;
    en         = 1'b0;
    buttonsRaw = '0;
    floorCode  = 4'h1;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput();
    rstN = 1'b1;

    $display("[TB] press latency and single set");
    repeat (9) applyStimulus(1'b0, 6'b000000, 4'h1);
    repeat (6) applyStimulus(1'b0, 6'b000100, 4'h1);
    checkValue("t1_before_e16", {2'b00, floorsTriggered}, 8'h00);
    applyStimulus(1'b0, 6'b000100, 4'h1);
    checkValue("t1_set_e16", {2'b00, floorsTriggered}, 8'h04);
    checkValue("t1_count_lag", {5'd0, pendingCount}, 8'h00);
    applyStimulus(1'b0, 6'b000100, 4'h1);
    checkValue("t1_count_e17", {5'd0, pendingCount}, 8'h01);
    repeat (10) applyStimulus(1'b0, 6'b000100, 4'h1);
    checkValue("t1_single", {2'b00, floorsTriggered}, 8'h04);
    repeat (8) applyStimulus(1'b0, 6'b000000, 4'h1);

    $display("[TB] short glitch");
    repeat (3) applyStimulus(1'b0, 6'b001000, 4'h1);
    repeat (10) applyStimulus(1'b0, 6'b000000, 4'h1);
    checkValue("t2_glitch", {2'b00, floorsTriggered}, 8'h04);

    $display("[TB] full dwell on floor 2");
    enTick(6'b000000, 4'h4, 10);
    checkValue("t3_dwell_start", {7'd0, dwellActive}, 8'h01);
    repeat (3) enTick(6'b000000, 4'h4, 10);
    checkValue("t3_tick4_kept", {2'b00, floorsTriggered}, 8'h04);
    enTick(6'b000000, 4'h4, 10);
    checkValue("t3_tick5_clear", {2'b00, floorsTriggered}, 8'h00);
    checkValue("t3_idle", {7'd0, dwellActive}, 8'h00);
    applyStimulus(1'b0, 6'b000000, 4'h4);
    checkValue("t3_count_zero", {5'd0, pendingCount}, 8'h00);

    $display("[TB] dwell abort on floor change");
    repeat (8) applyStimulus(1'b0, 6'b000100, 4'h4);
    repeat (8) applyStimulus(1'b0, 6'b000000, 4'h4);
    repeat (3) enTick(6'b000000, 4'h4, 3);
    checkValue("t4_dwelling", {7'd0, dwellActive}, 8'h01);
    applyStimulus(1'b0, 6'b000000, 4'h5);
    checkValue("t4_abort", {7'd0, dwellActive}, 8'h00);
    checkValue("t4_kept", {2'b00, floorsTriggered}, 8'h04);

    $display("[TB] press on the clearing tick");
    repeat (4) enTick(6'b000000, 4'h4, 2);
    checkValue("t5_dwelling", {7'd0, dwellActive}, 8'h01);
    repeat (6) applyStimulus(1'b0, 6'b000100, 4'h4);
    applyStimulus(1'b1, 6'b000100, 4'h4);
    checkValue("t5_set_wins", {2'b00, floorsTriggered}, 8'h04);
    checkValue("t5_back_idle", {7'd0, dwellActive}, 8'h00);
    applyStimulus(1'b1, 6'b000100, 4'h4);
    checkValue("t5_reopen", {7'd0, dwellActive}, 8'h01);
    repeat (8) applyStimulus(1'b0, 6'b000000, 4'h4);

    $display("[TB] out-of-range floor code and async reset");
    repeat (8) applyStimulus(1'b0, 6'b111111, 4'hE);
    repeat (8) applyStimulus(1'b0, 6'b000000, 4'hE);
    checkValue("t6_all_set", {2'b00, floorsTriggered}, 8'h3F);
    checkValue("t6_count6", {5'd0, pendingCount}, 8'h06);
    repeat (10) applyStimulus(1'b1, 6'b000000, 4'hE);
    checkValue("t6_no_dwell", {7'd0, dwellActive}, 8'h00);
    applyStimulus(1'b1, 6'b000000, 4'h4);
    checkValue("t6_dwell", {7'd0, dwellActive}, 8'h01);
    asyncReset();

    $display("[TB] randomized traffic");
    btnState = '0;
    flrState = 4'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NumFloors; i++)
        if ($urandom_range(0, 9) == 0) btnState[i] = ~btnState[i];
      if ($urandom_range(0, 39) == 0) begin
        flrState = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) != 0) flrState[0] = 1'b0;
      end
      applyStimulus(($urandom_range(0, 3) == 0), btnState, flrState);
      if (cyc % 1000 == 999) asyncReset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/floor_request_latch.md
Name: floor_request_latch

Overview:
Upstream stage of the elevator controller: turns raw, asynchronous hall-call buttons into the registered 6-bit floors_triggered request vector. Each button is synchronized, debounced and edge-detected, then latched as a pending request. A request is cleared only after the car has dwelt at that whole floor for DWELL_TICKS enable ticks. floors_triggered feeds the controller's floors_triggered input directly; the controller's floor output feeds back into this block.

Parameters:
NUM_FLOORS, 6, number of served floors; floor index i corresponds to controller floor code 2*i.
DEBOUNCE_CYCLES, 4, consecutive clk edges a synchronized input must differ from its stable value before the stable value flips (>=1).
DWELL_TICKS, 5, en ticks the car must remain at a requested whole floor before that request clears (>=1).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
en  in  1  timebase tick, same signal the controller uses
buttons_raw  in  NUM_FLOORS  asynchronous hall-call buttons, active-high
floor  in  4  controller floor code; bit0=1 means between floors, floor[3:1] is the floor index
floors_triggered  out  NUM_FLOORS  registered pending-request vector
dwell_active  out  1  high while a dwell is in progress
pending_count  out  3  popcount of floors_triggered, registered

Behaviour:
- Reset is asynchronous and active-low; one clock. While rst_n=0: floors_triggered=0, dwell_active=0, pending_count=0, all sync/debounce state 0, FSM in IDLE. Reset mid-dwell discards the dwell and all requests.
- Per button: 2-flop synchronizer -> debounce counter -> stable bit -> rising-edge press pulse (1 clk).
- Debounce: counter increments on each edge where sync != stable. It resets to 0 on any edge where sync == stable. On the edge where the counter would reach DEBOUNCE_CYCLES, stable flips and the counter resets.
- Press latency: buttons_raw held high from before edge E0. floors_triggered[i] is high after edge E0+2+DEBOUNCE_CYCLES (default E0+6).
- Glitches shorter than DEBOUNCE_CYCLES synchronized cycles produce no request. A button held high produces exactly one press. Release causes no action.
- Set: a press pulse sets floors_triggered[i]. Setting an already-set bit has no effect.
- FSM IDLE:
  - Condition: en=1, floor[0]=0, idx=floor[3:1] < NUM_FLOORS, and floors_triggered[idx]=1.
  - Action: go to DWELL, capture dwell_floor=idx, dwell_cnt=1, dwell_active=1.
  - idx >= NUM_FLOORS (codes 12-15) never starts a dwell.
- FSM DWELL:
  - On each en tick with floor == 2*dwell_floor: dwell_cnt increments.
  - When dwell_cnt == DWELL_TICKS on an en tick: clear floors_triggered[dwell_floor] on that edge and return to IDLE.
  - If floor differs from 2*dwell_floor on any clk edge: abort to IDLE, request kept.
  - DWELL_TICKS=1: dwell starts and completes on consecutive en ticks.
- Simultaneous set and clear of the same bit: set wins, bit stays 1, FSM still returns to IDLE. A new dwell may then start on the next qualifying en tick ("door reopen").
- A press for dwell_floor during DWELL also resets dwell_cnt to 1 (extends dwell).
- pending_count updates one edge after floors_triggered changes. Maximum value is 6 and fits in 3 bits.
- en=0: debounce and set logic keep running; the dwell FSM is frozen, except for the floor-change abort.

Optional Feature:
FLOOR_LOCK_EN:
- When defined: adds input lock_mask[NUM_FLOORS-1:0].
  - Press pulses on locked floors are ignored.
  - Any set bit whose lock_mask bit is 1 clears on the next edge.
  - A DWELL on a floor that becomes locked aborts to IDLE.
- When undefined: no lock_mask port; behaviour is exactly as above.

Decomposition:
- Shared package elevator_pkg:
  - NUM_FLOORS_C=6, FLOOR_W=4.
  - typedef floor_code_t (logic [3:0]) and req_vec_t (logic [5:0]).
  - enum dwell_state_t {IDLE, DWELL}.
  - Helper function floor_index(floor_code_t) returning floor[3:1].
- Sub-module button_debounce (synchronizer + debounce counter + press pulse), parameterized by DEBOUNCE_CYCLES; generate-instantiated NUM_FLOORS times.
- Request register, dwell FSM and popcount live in the top.

Test Plan:
1. Reset released, buttons_raw=6'b000100 held from edge 10 -> floors_triggered=6'b000100 after edge 16, pending_count=1 after edge 17, single set only.
2. buttons_raw[3] pulsed high for 3 clk (DEBOUNCE_CYCLES=4) -> floors_triggered stays 0.
3. Request 2 set, floor=4, en pulsed every 10 clk -> dwell_active rises on first tick, bit 2 clears on 5th tick, pending_count 1->0.
4. DWELL on floor 2 after 3 ticks, floor changes to 5 -> FSM IDLE, dwell_active=0, bit 2 still 1.
5. Press on floor 2 lands on the same edge as the clearing tick -> bit 2 remains 1, new dwell starts on next en tick.
6. floor=4'hE with all requests set, en ticking -> no dwell; drive rst_n low mid-DWELL -> all outputs 0 immediately, asynchronously.
